decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter LOAD_USE_STALL, default 1, meaning 1 enables load-use bubble insertion and 0 disables it because a downstream unit resolves the hazard.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instrValid_i  input  1  fetch offers instruction.
REQ-005 instr_i  input  32  RV32I instruction word.
REQ-006 pc_i  input  32  PC of instr_i.
REQ-007 instrReady_o  output  1  decode accepts instr_i this cycle.
REQ-008 flush_i  input  1  squash the held instruction and the instruction being accepted (branch redirect).
REQ-009 rs1Num_o, rs2Num_o  output  5 each  register-file read addresses, comb.
REQ-010 decValid_o  output  1  decoded bundle valid.
REQ-011 decReady_i  input  1  execute accepts bundle.
REQ-012 pc_o  output  32  registered PC.
REQ-013 imm_o  output  32  sign-extended immediate.
REQ-014 rdNum_o  output  5  destination register.
REQ-015 aluOp_o  output  4  ALU operation code from the package.
REQ-016 funct3_o  output  3  raw funct3 for branch and load/store width.
REQ-017 aluSrc_o, memRead_o, memWrite_o, regWrite_o, branch_o, jump_o, illegal_o  output  1 each  control flags.

Function
REQ-018 The block SHALL accept (fire) when instrValid_i && instrReady_o; on fire, the decoded bundle is registered and decValid_o=1 on the next edge.
REQ-019 instrReady_o SHALL equal (!decValid_o || decReady_i) && !stall && !flush_i.
REQ-020 A bundle with decValid_o=1 && decReady_i=0 SHALL hold all outputs unchanged.
REQ-021 rs1Num_o/rs2Num_o SHALL be instr_i[19:15]/[24:20] when instrReady_o=1, else the registered rs numbers of the held bundle, so the one-cycle-latency register file delivers operands aligned with decValid_o.
REQ-022 stall SHALL be LOAD_USE_STALL && decValid_o && memRead_o && rdNum_o!=0 && instrValid_i && (rdNum_o matches a source the incoming opcode actually reads).
REQ-023 When stall=1 and decReady_i=1, decValid_o SHALL be 0 on the next edge (one bubble), and instr_i is accepted one cycle later.
REQ-024 The immediate SHALL be I/S/B/U/J format per opcode, sign-extended from bit 31; B and J have bit 0 = 0; U has low 12 bits = 0.
REQ-025 A write to rd=x0 SHALL produce regWrite_o=0.
REQ-026 An unknown opcode SHALL produce illegal_o=1, regWrite_o=0, memRead_o=0, memWrite_o=0, branch_o=0, jump_o=0.
REQ-027 flush_i=1 SHALL clear decValid_o on the next edge regardless of decReady_i, and SHALL take priority over fire and stall.
REQ-028 Back-to-back flow SHALL sustain one instruction per cycle with zero bubbles when decReady_i=1 and no hazard.

Reset
REQ-029 rst=1 SHALL asynchronously force decValid_o=0 and all registered outputs (pc_o, imm_o, rdNum_o, aluOp_o, funct3_o, flags) to 0.
REQ-030 instrReady_o SHALL be 1 in the first cycle after rst deasserts; a reset asserted mid-stall drops the held bundle.

Structure
REQ-031 Opcode constants, the aluOp enum, and the packed dec_t bundle struct SHALL reside in shared package akarin_pkg.
REQ-032 Immediate generation SHALL be a separate combinational sub-module imm_gen (instr in, 32-bit imm out).

Verification
REQ-033 addi x5,x0,-1 (0xFFF00293) at pc 0x100 -> next cycle decValid_o=1, imm_o=0xFFFFFFFF, rdNum_o=5, regWrite_o=1, rs1Num_o at fire=0.
REQ-034 lw x6,0(x1) followed by add x7,x6,x2 -> one bubble (decValid_o=0 for one cycle), instrReady_o=0 for one cycle, add issued the next cycle.
REQ-035 decReady_i=0 for 3 cycles with bundle held -> outputs and rs1Num_o/rs2Num_o stable, instrReady_o=0.
REQ-036 flush_i=1 while bundle held and new instruction offered -> decValid_o=0 next cycle, instrReady_o=0 during flush.
REQ-037 beq with imm=-4 (0xFE000EE3) -> imm_o=0xFFFFFFFC, branch_o=1; opcode 0x7F -> illegal_o=1, all writes 0.
REQ-038 rst asserted mid-stream between edges -> decValid_o=0 immediately; first instruction after release decoded normally.

Source files
------------

// File: rtl/akarin_pkg.sv
// Shared decode definitions: RV32I opcode constants, the ALU operation
// enum, the registered decode bundle and helpers that say which source
// registers an opcode actually reads (used for load-use hazard detection).
package akarin_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } aluop_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        aluop_e      alu_op;
        logic [2:0]  funct3;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    function automatic logic reads_rs1(input logic [6:0] opc);
        return (opc == OPC_JALR)  || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_OPIMM)  || (opc == OPC_OP);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/execute-facing bus of the decode stage.
//   fetch side  : instrValid_i, instr_i, pc_i, flush_i -> instrReady_o
//   regfile     : rs1Num_o, rs2Num_o (read addresses)
//   execute side: decValid_o + bundle (pc_o, imm_o, rdNum_o, aluOp_o,
//                 funct3_o, control flags) <- decReady_i
// slave = decode stage, master = surrounding pipeline / bench.
interface decode_stage_if;
    import akarin_pkg::*;

    logic        instrValid_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        instrReady_o;
    logic        flush_i;
    logic [4:0]  rs1Num_o;
    logic [4:0]  rs2Num_o;
    logic        decValid_o;
    logic        decReady_i;
    logic [31:0] pc_o;
    logic [31:0] imm_o;
    logic [4:0]  rdNum_o;
    aluop_e      aluOp_o;
    logic [2:0]  funct3_o;
    logic        aluSrc_o;
    logic        memRead_o;
    logic        memWrite_o;
    logic        regWrite_o;
    logic        branch_o;
    logic        jump_o;
    logic        illegal_o;

    modport slave (
        input  instrValid_i, instr_i, pc_i, flush_i, decReady_i,
        output instrReady_o, rs1Num_o, rs2Num_o, decValid_o, pc_o, imm_o,
               rdNum_o, aluOp_o, funct3_o, aluSrc_o, memRead_o, memWrite_o,
               regWrite_o, branch_o, jump_o, illegal_o
    );

    modport master (
        output instrValid_i, instr_i, pc_i, flush_i, decReady_i,
        input  instrReady_o, rs1Num_o, rs2Num_o, decValid_o, pc_o, imm_o,
               rdNum_o, aluOp_o, funct3_o, aluSrc_o, memRead_o, memWrite_o,
               regWrite_o, branch_o, jump_o, illegal_o
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator.
//   instr : 32-bit instruction word
//   imm   : immediate for the opcode's format (I/S/B/U/J), sign-extended
//           from bit 31; zero for opcodes without an immediate.
module imm_gen
    import akarin_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with valid/ready handshakes on both sides.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : decode_stage_if.slave (fetch handshake, flush, register-file
//              read addresses, registered decode bundle to execute)
// LOAD_USE_STALL=1 inserts one bubble when the incoming instruction reads
// the destination of a load still held in this stage; 0 leaves the hazard
// to a downstream unit.
module decode_stage
    import akarin_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [4:0]  rd_in;
    logic [31:0] imm_d;
    dec_t        dec_d;
    dec_t        dec_p1;
    logic        vld_p1;
    logic        stall;
    logic        instr_ready;
    logic        fire;

    assign opc    = bus.instr_i[6:0];
    assign f3     = bus.instr_i[14:12];
    assign rs1_in = bus.instr_i[19:15];
    assign rs2_in = bus.instr_i[24:20];
    assign rd_in  = bus.instr_i[11:7];

    imm_gen u_imm_gen (
        .instr (bus.instr_i),
        .imm   (imm_d)
    );

    // alt selects SUB/SRA; the caller only raises it where funct7[5] is meaningful.
    function automatic aluop_e alu_from_funct(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Branch compares: eq/ne via subtract, signed and unsigned less-than.
    function automatic aluop_e alu_for_branch(input logic [2:0] fn3);
        case (fn3[2:1])
            2'b10:   return ALU_SLT;
            2'b11:   return ALU_SLTU;
            default: return ALU_SUB;
        endcase
    endfunction

    always_comb begin
        dec_d        = '0;
        dec_d.pc     = bus.pc_i;
        dec_d.imm    = imm_d;
        dec_d.rs1    = rs1_in;
        dec_d.rs2    = rs2_in;
        dec_d.rd     = rd_in;
        dec_d.funct3 = f3;
        dec_d.alu_op = ALU_ADD;
        case (opc)
            OPC_LUI: begin
                dec_d.alu_op    = ALU_PASSB;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.jump      = 1'b1;
            end
            OPC_BRANCH: begin
                dec_d.alu_op = alu_for_branch(f3);
                dec_d.branch = 1'b1;
            end
            OPC_LOAD: begin
                dec_d.alu_src   = 1'b1;
                dec_d.mem_read  = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec_d.alu_src   = 1'b1;
                dec_d.mem_write = 1'b1;
            end
            OPC_OPIMM: begin
                dec_d.alu_op    = alu_from_funct(f3, bus.instr_i[30] && (f3 == 3'd5));
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OPC_OP: begin
                dec_d.alu_op    = alu_from_funct(f3, bus.instr_i[30]);
                dec_d.reg_write = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Legal, but nothing for this pipeline to do.
            end
            default: begin
                dec_d.illegal = 1'b1;
            end
        endcase
        if (rd_in == 5'd0) begin
            dec_d.reg_write = 1'b0;
        end
    end

    // Only a held, valid load whose rd feeds a source the incoming opcode
    // really reads causes a bubble; x0 never creates a dependency.
    always_comb begin
        stall = 1'b0;
        if ((LOAD_USE_STALL != 0) && vld_p1 && dec_p1.mem_read &&
            (dec_p1.rd != 5'd0) && bus.instrValid_i) begin
            stall = (reads_rs1(opc) && (rs1_in == dec_p1.rd)) ||
                    (reads_rs2(opc) && (rs2_in == dec_p1.rd));
        end
    end

    assign instr_ready      = (!vld_p1 || bus.decReady_i) && !stall && !bus.flush_i;
    assign fire             = bus.instrValid_i && instr_ready;
    assign bus.instrReady_o = instr_ready;

    // Register-file reads take one cycle, so the addresses follow the
    // instruction being accepted, else stay on the held bundle's sources.
    assign bus.rs1Num_o = instr_ready ? rs1_in : dec_p1.rs1;
    assign bus.rs2Num_o = instr_ready ? rs2_in : dec_p1.rs2;

    // ---- stage boundary: fetch -> decoded bundle (p1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            dec_p1 <= '0;
        end else if (bus.flush_i) begin
            vld_p1 <= 1'b0;
        end else if (fire) begin
            vld_p1 <= 1'b1;
            dec_p1 <= dec_d;
        end else if (bus.decReady_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.decValid_o = vld_p1;
    assign bus.pc_o       = dec_p1.pc;
    assign bus.imm_o      = dec_p1.imm;
    assign bus.rdNum_o    = dec_p1.rd;
    assign bus.aluOp_o    = dec_p1.alu_op;
    assign bus.funct3_o   = dec_p1.funct3;
    assign bus.aluSrc_o   = dec_p1.alu_src;
    assign bus.memRead_o  = dec_p1.mem_read;
    assign bus.memWrite_o = dec_p1.mem_write;
    assign bus.regWrite_o = dec_p1.reg_write;
    assign bus.branch_o   = dec_p1.branch;
    assign bus.jump_o     = dec_p1.jump;
    assign bus.illegal_o  = dec_p1.illegal;

endmodule
